// File: rtl/sr_cmd_arbiter.sv
// Round-robin arbiter feeding a registered SR command port that drives an NFLAG-bit flag bank.
// Define SR_TOGGLE_EN to make command 11 toggle the addressed flag instead of raising err.
module sr_cmd_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_sr,
    input  logic [IDXW*NREQ-1:0] req_idx,
    input  logic                 clr_all,
    output logic [NREQ-1:0]      gnt,
    output logic                 sr_valid,
    output logic [1:0]           sr_out,
    output logic [IDXW-1:0]      sr_idx,
    output logic                 err,
    output logic [NFLAG-1:0]     q,
    output logic [NFLAG-1:0]     qb
);

    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             sr_valid_q, sr_valid_d;
    logic [1:0]       sr_out_q, sr_out_d;
    logic [IDXW-1:0]  sr_idx_q, sr_idx_d;
    logic             err_q, err_d;
    logic [NFLAG-1:0] q_q, q_d;
    logic [RRW-1:0]   rr_q, rr_d;

    logic [NREQ-1:0]  elig;
    logic [RRW-1:0]   cand;
    logic             found;
    int               win;

    // Stage A: a requester holding gnt this cycle is skipped, capping it at one grant per 2 cycles.
    always_comb begin
        gnt_d      = '0;
        sr_valid_d = 1'b0;
        sr_out_d   = sr_out_q;
        sr_idx_d   = sr_idx_q;
        rr_d       = rr_q;
        elig       = req & ~gnt_q;
        found      = 1'b0;
        win        = 0;
        cand       = '0;
        if (!clr_all) begin
            for (int off = 0; off < NREQ; off++) begin
                cand = RRW'((int'(rr_q) + off) % NREQ);
                if (!found && elig[cand]) begin
                    found = 1'b1;
                    win   = int'(cand);
                end
            end
            if (found) begin
                gnt_d      = NREQ'(1) << win;
                sr_valid_d = 1'b1;
                sr_out_d   = 2'(req_sr >> (2 * win));
                sr_idx_d   = IDXW'(req_idx >> (IDXW * win));
                rr_d       = RRW'((win + 1) % NREQ);
            end
        end
    end

    // Stage B: bulk clear overrides and silently drops any write due at the same edge.
    always_comb begin
        q_d   = q_q;
        err_d = 1'b0;
        if (clr_all) begin
            q_d = '0;
        end else if (sr_valid_q) begin
            if (int'(sr_idx_q) >= NFLAG) begin
                err_d = 1'b1;
            end else begin
                for (int i = 0; i < NFLAG; i++) begin
                    if (sr_idx_q == IDXW'(i)) begin
                        case (sr_out_q)
                            2'b01: q_d[i] = 1'b0;
                            2'b10: q_d[i] = 1'b1;
`ifdef SR_TOGGLE_EN
                            2'b11: q_d[i] = ~q_q[i];
`else
                            2'b11: err_d = 1'b1;
`endif
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q      <= '0;
            sr_valid_q <= 1'b0;
            sr_out_q   <= 2'b00;
            sr_idx_q   <= '0;
            err_q      <= 1'b0;
            q_q        <= '0;
            rr_q       <= '0;
        end else begin
            gnt_q      <= gnt_d;
            sr_valid_q <= sr_valid_d;
            sr_out_q   <= sr_out_d;
            sr_idx_q   <= sr_idx_d;
            err_q      <= err_d;
            q_q        <= q_d;
            rr_q       <= rr_d;
        end
    end

    assign gnt      = gnt_q;
    assign sr_valid = sr_valid_q;
    assign sr_out   = sr_out_q;
    assign sr_idx   = sr_idx_q;
    assign err      = err_q;
    assign q        = q_q;
    assign qb       = ~q_q;

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// Directed bench for sr_cmd_arbiter: issued commands go through a scoreboard queue,
// flag bank and err are checked against hand-computed values. NFLAG=6 so index 7 is out of range.
module tb_sr_cmd_arbiter;

    localparam int NREQ  = 4;
    localparam int NFLAG = 6;
    localparam int IDXW  = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [2*NREQ-1:0]    req_sr = '0;
    logic [IDXW*NREQ-1:0] req_idx = '0;
    logic                 clr_all = 1'b0;
    logic [NREQ-1:0]      gnt;
    logic                 sr_valid;
    logic [1:0]           sr_out;
    logic [IDXW-1:0]      sr_idx;
    logic                 err;
    logic [NFLAG-1:0]     q;
    logic [NFLAG-1:0]     qb;

    sr_cmd_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_sr(req_sr), .req_idx(req_idx),
        .clr_all(clr_all), .gnt(gnt), .sr_valid(sr_valid), .sr_out(sr_out),
        .sr_idx(sr_idx), .err(err), .q(q), .qb(qb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] g;
        logic [1:0]      sr;
        logic [IDXW-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    logic [NREQ-1:0] prev_gnt = '0;
    logic [NFLAG-1:0] q_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic push(input logic [NREQ-1:0] g, input logic [1:0] sr, input logic [IDXW-1:0] idx);
        exp_t e;
        e.g = g; e.sr = sr; e.idx = idx;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [1:0] sr, input logic [IDXW-1:0] idx);
        req[i] = 1'b1;
        req_sr[2*i +: 2] = sr;
        req_idx[IDXW*i +: IDXW] = idx;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every issued command must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (sr_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_cmd: got gnt=%b sr=%b idx=%0d want none", gnt, sr_out, sr_idx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("cmd_gnt", 32'(gnt), 32'(e.g));
                    chk("cmd_sr", 32'(sr_out), 32'(e.sr));
                    chk("cmd_idx", 32'(sr_idx), 32'(e.idx));
                end
                chk("no_back_to_back_gnt", 32'(gnt & prev_gnt), 32'd0);
            end
            prev_gnt = gnt;
        end else begin
            prev_gnt = '0;
        end
    end

    initial begin
        // reset
        tick(); tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_sr_valid", 32'(sr_valid), 32'd0);
        chk("rst_sr_out", 32'(sr_out), 32'd0);
        chk("rst_sr_idx", 32'(sr_idx), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_qb", 32'(qb), 32'h3F);
        rst = 1'b0;
        tick();

        // single request: set flag 3
        set_req(0, 2'b10, 3'd3);
        push(4'b0001, 2'b10, 3'd3);
        tick();
        chk("single_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        chk("single_q", 32'(q), 32'h08);
        chk("single_qb", 32'(qb), 32'h37);
        chk("single_err", 32'(err), 32'd0);

        // fairness: pointer sits at 1, so order is 1,2,3,0,1
        set_req(0, 2'b10, 3'd0);
        set_req(1, 2'b10, 3'd1);
        set_req(2, 2'b10, 3'd2);
        set_req(3, 2'b10, 3'd4);
        push(4'b0010, 2'b10, 3'd1);
        push(4'b0100, 2'b10, 3'd2);
        push(4'b1000, 2'b10, 3'd4);
        push(4'b0001, 2'b10, 3'd0);
        push(4'b0010, 2'b10, 3'd1);
        repeat (5) tick();
        req = '0;
        tick();
        chk("rr_q", 32'(q), 32'h1F);
        chk("rr_drain", 32'(sr_valid), 32'd0);

        // set then reset flag 5 on consecutive cycles
        set_req(1, 2'b10, 3'd5);
        push(4'b0010, 2'b10, 3'd5);
        tick();
        req = '0;
        set_req(2, 2'b01, 3'd5);
        push(4'b0100, 2'b01, 3'd5);
        tick();
        req = '0;
        chk("sr_set_q", 32'(q), 32'h3F);
        tick();
        chk("sr_reset_q", 32'(q), 32'h1F);

        // clr_all vs a pending illegal write and a new request
        set_req(0, 2'b11, 3'd2);
        push(4'b0001, 2'b11, 3'd2);
        tick();
        req = '0;
        set_req(1, 2'b10, 3'd4);
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        chk("clr_q", 32'(q), 32'd0);
        chk("clr_gnt", 32'(gnt), 32'd0);
        chk("clr_sr_valid", 32'(sr_valid), 32'd0);
        chk("clr_err", 32'(err), 32'd0);
        push(4'b0010, 2'b10, 3'd4);
        tick();
        chk("after_clr_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        chk("after_clr_q", 32'(q), 32'h10);
        chk("after_clr_err", 32'(err), 32'd0);

        // illegal 11 to flag 2
        set_req(2, 2'b11, 3'd2);
        push(4'b0100, 2'b11, 3'd2);
        tick();
        req = '0;
        chk("ill_err_early", 32'(err), 32'd0);
        tick();
`ifdef SR_TOGGLE_EN
        q_exp = 6'h14;
        chk("ill_err", 32'(err), 32'd0);
`else
        q_exp = 6'h10;
        chk("ill_err", 32'(err), 32'd1);
`endif
        chk("ill_q", 32'(q), 32'(q_exp));
        tick();
        chk("ill_err_pulse", 32'(err), 32'd0);

        // out-of-range index 7
        set_req(3, 2'b10, 3'd7);
        push(4'b1000, 2'b10, 3'd7);
        tick();
        req = '0;
        tick();
        chk("oor_err", 32'(err), 32'd1);
        chk("oor_q", 32'(q), 32'(q_exp));
        tick();
        chk("oor_err_pulse", 32'(err), 32'd0);

        // reset while a command is in flight
        set_req(0, 2'b10, 3'd0);
        push(4'b0001, 2'b10, 3'd0);
        tick();
        req = '0;
        chk("mid_valid", 32'(sr_valid), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_q", 32'(q), 32'd0);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_valid", 32'(sr_valid), 32'd0);
        chk("mid_rst_qb", 32'(qb), 32'h3F);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("post_rst_q", 32'(q), 32'd0);
        chk("post_rst_err", 32'(err), 32'd0);
        chk("post_rst_valid", 32'(sr_valid), 32'd0);

        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
